round_pack_unit: RTL

- Back end of the FP multiply/divide datapath; consumes the normalized 27-bit mantissa (1.F + GRS) and 8-bit exponent produced by the normalization stage.
- Applies IEEE-754 single-precision rounding, handles rounding carry-out, overflow, underflow and special operands, then packs a 32-bit result with exception flags.
- Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/round_pack_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/round_pack_unit.sv
// round_pack_unit: IEEE-754 single rounding, classification and packing in a two-stage valid/ready pipeline
module round_pack_unit #(
   parameter int          ROUND_MODE   = 0,
   parameter logic [31:0] QNAN_PAYLOAD = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [26:0] in_mant,
   input  logic [7:0]  in_exp,
   input  logic        in_underflow,
   input  logic        in_overflow,
   input  logic        in_is_nan,
   input  logic        in_is_inf,
   input  logic        in_is_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_overflow,
   output logic        out_underflow,
   output logic        out_inexact,
   output logic        out_invalid
);
   logic        s1_valid, s2_valid, s1_advance;
   logic        s1_sign, s1_inexact, s1_mant_nz, s1_uf, s1_of, s1_nan, s1_inf, s1_zero;
   logic [8:0]  s1_exp;
   logic [22:0] s1_frac;
   logic        round_up;
   logic [24:0] sum;
   logic [8:0]  exp_r;
   logic [22:0] frac;
   logic        cls_of, cls_uf, quiet;
   logic [31:0] n_result;
   logic        n_of, n_uf, n_inx;

   assign s1_advance = !s2_valid || out_ready;
   assign in_ready   = !s1_valid || s1_advance;
   assign out_valid  = s2_valid;

   // round the incoming mantissa ahead of the stage-1 register
   always_comb begin
      round_up = (ROUND_MODE == 0) && in_mant[2] && (in_mant[1] || in_mant[0] || in_mant[3]);
      sum      = {1'b0, in_mant[26:3]} + {24'b0, round_up};
      exp_r    = {1'b0, in_exp} + {8'b0, sum[24]};
      frac     = sum[24] ? sum[23:1] : sum[22:0];
   end

   // stage 1: hold the rounded operand and its special-case flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_exp     <= '0;
         s1_frac    <= '0;
         s1_inexact <= 1'b0;
         s1_mant_nz <= 1'b0;
         s1_uf      <= 1'b0;
         s1_of      <= 1'b0;
         s1_nan     <= 1'b0;
         s1_inf     <= 1'b0;
         s1_zero    <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign    <= in_sign;
            s1_exp     <= exp_r;
            s1_frac    <= frac;
            s1_inexact <= |in_mant[2:0];
            s1_mant_nz <= |in_mant;
            s1_uf      <= in_underflow;
            s1_of      <= in_overflow;
            s1_nan     <= in_is_nan;
            s1_inf     <= in_is_inf;
            s1_zero    <= in_is_zero;
         end
      end
   end

   // classify by priority (NaN, Inf, overflow, zero, underflow, normal) and pack
   always_comb begin
      cls_of   = s1_of || (s1_exp >= 9'h0FF);
      cls_uf   = s1_uf || (s1_exp == 9'h000) || !s1_mant_nz;
      quiet    = s1_nan || s1_inf;
      n_result = s1_nan ? QNAN_PAYLOAD :
                 (s1_inf || cls_of) ? {s1_sign, 8'hFF, 23'h0} :
                 (s1_zero || cls_uf) ? {s1_sign, 31'h0} :
                 {s1_sign, s1_exp[7:0], s1_frac};
      n_of     = !quiet && cls_of;
      n_uf     = !quiet && !cls_of && !s1_zero && cls_uf;
      n_inx    = quiet ? 1'b0 : cls_of ? 1'b1 : s1_zero ? 1'b0 : cls_uf ? s1_mant_nz : s1_inexact;
   end

   // stage 2: registered result, held while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid      <= 1'b0;
         out_result    <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_inexact   <= 1'b0;
         out_invalid   <= 1'b0;
      end else if (s1_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_result    <= n_result;
            out_overflow  <= n_of;
            out_underflow <= n_uf;
            out_inexact   <= n_inx;
            out_invalid   <= s1_nan;
         end
      end
   end
endmodule
